// File: rtl/inst_decode_stage_if.sv
// IF/ID -> ID -> ID/EX bundle for the instruction-decode stage.
// The stage has no valid/ready pair: it advances every clock edge, and
// flush (clear the ID/EX register) and hazard (insert a bubble) are the
// only flow controls. The master drives the instruction fields, flow
// controls and write-back port; the slave (the decode stage) returns the
// combinational source indices and the registered ID/EX contents.
interface inst_decode_stage_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             hazard;
  logic [WIDTH-1:0] pc_in;
  logic [3:0]       cond;
  logic [3:0]       op_code;
  logic [1:0]       mode;
  logic             imm;
  logic             status;
  logic [3:0]       rn;
  logic [3:0]       rd;
  logic [11:0]      shifter_opr;
  logic [23:0]      signed_imm24;
  logic [3:0]       nzcv;
  logic             wb_en_in;
  logic [3:0]       wb_dest;
  logic [WIDTH-1:0] wb_value;

  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] val_rn;
  logic [WIDTH-1:0] val_rm;
  logic [3:0]       exe_cmd;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             wb_en;
  logic             b;
  logic             s;
  logic             imm_out;
  logic [11:0]      shifter_opr_out;
  logic [23:0]      signed_imm24_out;
  logic [3:0]       dest;

  modport master (
    output flush, hazard, pc_in, cond, op_code, mode, imm, status, rn, rd,
           shifter_opr, signed_imm24, nzcv, wb_en_in, wb_dest, wb_value,
    input  src1, src2, two_src, pc_out, val_rn, val_rm, exe_cmd, mem_r_en,
           mem_w_en, wb_en, b, s, imm_out, shifter_opr_out,
           signed_imm24_out, dest
  );

  modport slave (
    input  flush, hazard, pc_in, cond, op_code, mode, imm, status, rn, rd,
           shifter_opr, signed_imm24, nzcv, wb_en_in, wb_dest, wb_value,
    output src1, src2, two_src, pc_out, val_rn, val_rm, exe_cmd, mem_r_en,
           mem_w_en, wb_en, b, s, imm_out, shifter_opr_out,
           signed_imm24_out, dest
  );
endinterface

// File: rtl/inst_decode_stage.sv
// ARM instruction-decode stage: control decode, condition check, 15-entry
// register file (R0..R14) and the ID/EX pipeline register.
// Optional macro WB_BYPASS_EN: a same-cycle write-back to the register being
// read is forwarded into val_rn/val_rm. Without it, reads see the old value
// and the written value appears from the next cycle.
// WIDTH must match the WIDTH of the connected interface instance.
module inst_decode_stage #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  inst_decode_stage_if.slave bus
);

  logic [WIDTH-1:0] rf [0:14];

  logic [3:0]       exe_cmd_d;
  logic             mem_r_d;
  logic             mem_w_d;
  logic             wb_d;
  logic             b_d;
  logic             s_d;
  logic             cond_ok;
  logic             is_str;
  logic [WIDTH-1:0] rn_old;
  logic [WIDTH-1:0] rm_old;
  logic [WIDTH-1:0] rn_val;
  logic [WIDTH-1:0] rm_val;

  // STR stores Rd, so its second source is the Rd index rather than Rm.
  assign is_str       = (bus.mode == 2'b01) && !bus.status;
  assign bus.src1     = bus.rn;
  assign bus.src2     = is_str ? bus.rd : bus.shifter_opr[3:0];
  assign bus.two_src  = ((bus.mode == 2'b00) && !bus.imm) ||
                        ((bus.mode == 2'b01) && !bus.status);

  // Decode mode/opcode into execute, memory and write-back control.
  always_comb begin
    exe_cmd_d = 4'b0000;
    mem_r_d   = 1'b0;
    mem_w_d   = 1'b0;
    wb_d      = 1'b0;
    b_d       = 1'b0;
    s_d       = 1'b0;
    case (bus.mode)
      2'b00: begin
        s_d  = bus.status;
        wb_d = 1'b1;
        case (bus.op_code)
          4'b1101: exe_cmd_d = 4'b0001;  // MOV
          4'b1111: exe_cmd_d = 4'b1001;  // MVN
          4'b0100: exe_cmd_d = 4'b0010;  // ADD
          4'b0101: exe_cmd_d = 4'b0011;  // ADC
          4'b0010: exe_cmd_d = 4'b0100;  // SUB
          4'b0110: exe_cmd_d = 4'b0101;  // SBC
          4'b0000: exe_cmd_d = 4'b0110;  // AND
          4'b1100: exe_cmd_d = 4'b0111;  // ORR
          4'b0001: exe_cmd_d = 4'b1000;  // EOR
          4'b1010: begin exe_cmd_d = 4'b0100; wb_d = 1'b0; end  // CMP
          4'b1000: begin exe_cmd_d = 4'b0110; wb_d = 1'b0; end  // TST
          default: begin wb_d = 1'b0; s_d = 1'b0; end
        endcase
      end
      2'b01: begin
        exe_cmd_d = 4'b0010;
        mem_r_d   = bus.status;
        mem_w_d   = !bus.status;
        wb_d      = bus.status;
      end
      2'b10:   b_d = 1'b1;
      default: ;
    endcase
  end

  // Evaluate the condition field against the current NZCV flags.
  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      4'b0000: cond_ok = bus.nzcv[2];
      4'b0001: cond_ok = !bus.nzcv[2];
      4'b0010: cond_ok = bus.nzcv[1];
      4'b0011: cond_ok = !bus.nzcv[1];
      4'b0100: cond_ok = bus.nzcv[3];
      4'b0101: cond_ok = !bus.nzcv[3];
      4'b0110: cond_ok = bus.nzcv[0];
      4'b0111: cond_ok = !bus.nzcv[0];
      4'b1000: cond_ok = bus.nzcv[1] && !bus.nzcv[2];
      4'b1001: cond_ok = !bus.nzcv[1] || bus.nzcv[2];
      4'b1010: cond_ok = (bus.nzcv[3] == bus.nzcv[0]);
      4'b1011: cond_ok = (bus.nzcv[3] != bus.nzcv[0]);
      4'b1100: cond_ok = !bus.nzcv[2] && (bus.nzcv[3] == bus.nzcv[0]);
      4'b1101: cond_ok = bus.nzcv[2] || (bus.nzcv[3] != bus.nzcv[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Asynchronous register reads; index 15 is not backed by storage and reads 0.
  always_comb begin
    rn_old = (bus.rn == 4'd15) ? '0 : rf[bus.rn];
    rm_old = (bus.src2 == 4'd15) ? '0 : rf[bus.src2];
`ifdef WB_BYPASS_EN
    rn_val = (bus.wb_en_in && bus.rn != 4'd15 && bus.wb_dest == bus.rn)
             ? bus.wb_value : rn_old;
    rm_val = (bus.wb_en_in && bus.src2 != 4'd15 && bus.wb_dest == bus.src2)
             ? bus.wb_value : rm_old;
`else
    rn_val = rn_old;
    rm_val = rm_old;
`endif
  end

  // Register file: reset loads Ri = i; write-back port writes R0..R14.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf[i] <= WIDTH'(i);
    end else if (bus.wb_en_in && bus.wb_dest != 4'd15) begin
      rf[bus.wb_dest] <= bus.wb_value;
    end
  end

  // ID/EX register: rst/flush clear everything, hazard or failed condition
  // zero the control bits while the data fields are still captured.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      bus.pc_out           <= '0;
      bus.val_rn           <= '0;
      bus.val_rm           <= '0;
      bus.exe_cmd          <= 4'b0000;
      bus.mem_r_en         <= 1'b0;
      bus.mem_w_en         <= 1'b0;
      bus.wb_en            <= 1'b0;
      bus.b                <= 1'b0;
      bus.s                <= 1'b0;
      bus.imm_out          <= 1'b0;
      bus.shifter_opr_out  <= 12'd0;
      bus.signed_imm24_out <= 24'd0;
      bus.dest             <= 4'd0;
    end else begin
      bus.pc_out           <= bus.pc_in;
      bus.val_rn           <= rn_val;
      bus.val_rm           <= rm_val;
      bus.imm_out          <= bus.imm;
      bus.shifter_opr_out  <= bus.shifter_opr;
      bus.signed_imm24_out <= bus.signed_imm24;
      bus.dest             <= bus.rd;
      if (bus.hazard || !cond_ok) begin
        bus.exe_cmd  <= 4'b0000;
        bus.mem_r_en <= 1'b0;
        bus.mem_w_en <= 1'b0;
        bus.wb_en    <= 1'b0;
        bus.b        <= 1'b0;
        bus.s        <= 1'b0;
      end else begin
        bus.exe_cmd  <= exe_cmd_d;
        bus.mem_r_en <= mem_r_d;
        bus.mem_w_en <= mem_w_d;
        bus.wb_en    <= wb_d;
        bus.b        <= b_d;
        bus.s        <= s_d;
      end
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed cases then randomized instructions,
// checked against a table-driven reference model through an expected queue.
module tb_inst_decode_stage;

  localparam int W = 32;

  typedef struct {
    logic        rst, flush, hazard;
    logic [31:0] pc;
    logic [3:0]  cond, op;
    logic [1:0]  mode;
    logic        imm, status;
    logic [3:0]  rn, rd;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  nzcv;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_val;
  } stim_t;

  // ctrl = {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}
  // fields = {imm_out, shifter_opr_out, signed_imm24_out, dest}
  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn_v;
    logic [31:0] rm_v;
    logic [40:0] fields;
  } exp_t;

  // ALU command per data-processing opcode (-1 = not an instruction) and
  // whether that opcode writes a result register.
  localparam int DP_CMD [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
  localparam bit DP_WB  [16] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] m_rf [15];

  inst_decode_stage_if #(.WIDTH(W)) bus ();

  inst_decode_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM conditions come in pairs: even code tests a base predicate, odd code
  // its negation; 1110 is always, 1111 never.
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [31:0] read_model(input logic [3:0] idx, input stim_t s);
    if (idx == 4'd15) return 32'd0;
`ifdef WB_BYPASS_EN
    if (s.wb_en && s.wb_dest == idx) return s.wb_val;
`endif
    return m_rf[idx];
  endfunction

  function automatic logic [8:0] ctrl_model(input stim_t s);
    logic [3:0] cmd;
    bit mr, mw, wb, br, sf;
    cmd = 4'd0; mr = 0; mw = 0; wb = 0; br = 0; sf = 0;
    if (s.mode == 2'd0 && DP_CMD[s.op] >= 0) begin
      cmd = 4'(DP_CMD[s.op]);
      wb  = DP_WB[s.op];
      sf  = s.status;
    end else if (s.mode == 2'd1) begin
      cmd = 4'd2;
      mr  = s.status;
      mw  = ~s.status;
      wb  = s.status;
    end else if (s.mode == 2'd2) begin
      br = 1;
    end
    if (s.hazard || !cond_holds(s.cond, s.nzcv)) return 9'd0;
    return {cmd, mr, mw, wb, br, sf};
  endfunction

  // Drive one instruction, queue its expected ID/EX contents, check the
  // combinational outputs, then advance the register file model.
  task automatic step(input stim_t s);
    exp_t e;
    logic [3:0] s2;
    @(negedge clk);
    rst              = s.rst;
    bus.flush        = s.flush;
    bus.hazard       = s.hazard;
    bus.pc_in        = s.pc;
    bus.cond         = s.cond;
    bus.op_code      = s.op;
    bus.mode         = s.mode;
    bus.imm          = s.imm;
    bus.status       = s.status;
    bus.rn           = s.rn;
    bus.rd           = s.rd;
    bus.shifter_opr  = s.shop;
    bus.signed_imm24 = s.simm;
    bus.nzcv         = s.nzcv;
    bus.wb_en_in     = s.wb_en;
    bus.wb_dest      = s.wb_dest;
    bus.wb_value     = s.wb_val;
    s2 = (s.mode == 2'd1 && !s.status) ? s.rd : s.shop[3:0];
    if (s.rst || s.flush) begin
      e = '0;
    end else begin
      e.ctrl   = ctrl_model(s);
      e.pc     = s.pc;
      e.rn_v   = read_model(s.rn, s);
      e.rm_v   = read_model(s2, s);
      e.fields = {s.imm, s.shop, s.simm, s.rd};
    end
    exp_q.push_back(e);
    #1;
    check("src1", 64'(bus.src1), 64'(s.rn));
    check("src2", 64'(bus.src2), 64'(s2));
    check("two_src", 64'(bus.two_src),
          64'((s.mode == 2'd0 && !s.imm) || (s.mode == 2'd1 && !s.status)));
    if (s.rst) begin
      for (int i = 0; i < 15; i++) m_rf[i] = 32'(i);
    end else if (s.wb_en && s.wb_dest != 4'd15) begin
      m_rf[s.wb_dest] = s.wb_val;
    end
  endtask

  // Scoreboard monitor: one ID/EX result per edge after each queued step.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ctrl", 64'({bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.b, bus.s}),
            64'(mon_e.ctrl));
      check("pc_out", 64'(bus.pc_out), 64'(mon_e.pc));
      check("val_rn", 64'(bus.val_rn), 64'(mon_e.rn_v));
      check("val_rm", 64'(bus.val_rm), 64'(mon_e.rm_v));
      check("fields", 64'({bus.imm_out, bus.shifter_opr_out, bus.signed_imm24_out, bus.dest}),
            64'(mon_e.fields));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.mode = 2'b11;
    s.cond = 4'hE;
    return s;
  endfunction

  function automatic stim_t add_al(input logic [3:0] rn, input logic [3:0] rm);
    stim_t s;
    s = idle();
    s.mode = 2'b00; s.op = 4'b0100; s.status = 1'b1; s.imm = 1'b0;
    s.rn = rn; s.rd = 4'd9; s.shop = {8'h00, rm}; s.pc = 32'h0000_0040;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst     = ($urandom_range(0, 49) == 0);
    s.flush   = ($urandom_range(0, 9) == 0);
    s.hazard  = ($urandom_range(0, 9) == 0);
    s.pc      = $urandom;
    s.cond    = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    s.op      = 4'($urandom_range(0, 15));
    s.mode    = 2'($urandom_range(0, 3));
    s.imm     = 1'($urandom_range(0, 1));
    s.status  = 1'($urandom_range(0, 1));
    s.rn      = 4'($urandom_range(0, 15));
    s.rd      = 4'($urandom_range(0, 15));
    s.shop    = 12'($urandom);
    s.simm    = 24'($urandom);
    s.nzcv    = 4'($urandom_range(0, 15));
    s.wb_en   = 1'($urandom_range(0, 1));
    s.wb_dest = ($urandom_range(0, 3) == 0) ? s.rn : 4'($urandom_range(0, 15));
    s.wb_val  = $urandom;
    return s;
  endfunction

  // Directed cases, random stream, drain and report.
  initial begin
    stim_t s;
    bus.flush = 0; bus.hazard = 0; bus.pc_in = '0; bus.cond = '0; bus.op_code = '0;
    bus.mode = '0; bus.imm = 0; bus.status = 0; bus.rn = '0; bus.rd = '0;
    bus.shifter_opr = '0; bus.signed_imm24 = '0; bus.nzcv = '0; bus.wb_en_in = 0;
    bus.wb_dest = '0; bus.wb_value = '0;

    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    s = idle(); step(s);
    s = idle(); s.rn = 4'd7; step(s);

    s = add_al(4'd2, 4'd3); step(s);

    s = idle(); s.mode = 2'b01; s.status = 1'b0; s.rn = 4'd1; s.rd = 4'd5; step(s);
    s.status = 1'b1; step(s);

    s = add_al(4'd6, 4'd8); s.cond = 4'h0; s.nzcv = 4'b0000; step(s);
    s.nzcv = 4'b0100; step(s);

    s = idle(); s.rn = 4'd4; s.wb_en = 1'b1; s.wb_dest = 4'd4; s.wb_val = 32'hDEAD_BEEF;
    step(s);
    s = idle(); s.rn = 4'd4; step(s);

    s = add_al(4'd2, 4'd3); s.flush = 1'b1; s.hazard = 1'b1; step(s);
    s = add_al(4'd2, 4'd3); s.hazard = 1'b1; s.pc = 32'h0000_0100; step(s);
    s = idle(); s.rn = 4'd15; s.shop = 12'h00F; step(s);

    for (int i = 0; i < 400; i++) step(rand_stim());
    step(idle());

    repeat (3) @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Instruction-decode (ID) stage of the 32-bit ARM pipeline, directly downstream of the instruction-fetch register. It takes the instruction fields and PC+4 from the IF/ID register, decodes them into execute/memory/write-back control, checks the condition code against NZCV, reads operands from a 15-entry register file, and captures everything in the ID/EX pipeline register. The register file write port is driven from the write-back stage.

## Interface
- WIDTH, 32, datapath and register width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch taken; ID/EX register cleared next edge
- hazard  in  1  data hazard; bubble (all control zero) captured into ID/EX
- pc_in  in  WIDTH  PC+4 from IF/ID register
- cond, op_code  in  4 each  instruction [31:28], [24:21]
- mode  in  2  instruction [27:26]
- imm, status  in  1 each  I bit [25], S/L bit [20]
- rn, rd  in  4 each  instruction [19:16], [15:12]
- shifter_opr  in  12  instruction [11:0]
- signed_imm24  in  24  instruction [23:0]
- nzcv  in  4  current status register {N,Z,C,V}
- wb_en_in  in  1  write-back enable
- wb_dest  in  4  write-back register index (0..14)
- wb_value  in  WIDTH  write-back data
- src1, src2  out  4 each  combinational: rn; rd if STR, else shifter_opr[3:0]
- two_src  out  1  combinational: (mode==00 & ~imm) | (mode==01 & ~status)
- pc_out, val_rn, val_rm  out  WIDTH each  registered PC, Rn value, Rm/Rd value
- exe_cmd  out  4  registered ALU command
- mem_r_en, mem_w_en, wb_en, b, s  out  1 each  registered control
- imm_out, shifter_opr_out, signed_imm24_out, dest  out  1/12/24/4  registered fields

## Operation
- Data processing (mode 00): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000 (wb_en=1); CMP 1010->0100, TST 1000->0110 (wb_en=0); s=status. Unlisted opcodes: all control 0.
- Memory (mode 01): status=1 LDR: exe_cmd 0010, mem_r_en=1, wb_en=1; status=0 STR: exe_cmd 0010, mem_w_en=1; s=0.
- Branch (mode 10): b=1, all other control 0. Mode 11: all control 0.
- Condition check: EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V; HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V); AL 1110 true; 1111 false. Failed condition or hazard: exe_cmd, mem_r_en, mem_w_en, wb_en, b, s forced 0; data fields still captured.
- Register file: R0..R14; write at rising edge when wb_en_in=1 and wb_dest!=15; reads asynchronous; reading index 15 returns 0.

## Timing
- ID/EX latency: 1 cycle; every registered output reflects inputs of the previous edge.
- Priority at each edge: rst > flush > hazard > normal capture.
- rst: all ID/EX outputs 0; register file Ri loaded with i (R0=0 ... R14=14).
- flush: all ID/EX outputs 0 (pc_out included); register file write still occurs.
- Write and read of the same register in one cycle: see Configuration.
- Reset mid-operation discards in-flight ID/EX contents and any same-cycle write.

## Configuration
- WB_BYPASS_EN defined: if wb_en_in=1 and wb_dest equals the read index (≠15), val_rn/val_rm capture wb_value in the same cycle.
- Undefined: reads return the old register contents; the new value is visible from the next cycle.

## Test plan
- Reset, then idle cycle -> all registered outputs 0; reading R7 via rn=7 gives val_rn=7 next cycle.
- ADD AL, rn=2, shifter_opr[3:0]=3, imm=0, S=1 -> exe_cmd=0010, wb_en=1, s=1, val_rn=2, val_rm=3, two_src=1.
- STR, rd=5, rn=1 -> src2=5, mem_w_en=1, wb_en=0, exe_cmd=0010; LDR -> mem_r_en=1, wb_en=1.
- ADDEQ with nzcv=0000 -> all control 0; with nzcv=0100 -> wb_en=1.
- wb_en_in=1, wb_dest=4, wb_value=0xDEADBEEF while rn=4 -> val_rn=0xDEADBEEF with WB_BYPASS_EN, 4 without; next cycle 0xDEADBEEF both.
- flush and hazard asserted together with valid ADD -> all outputs 0; hazard alone -> control 0, pc_out/val_rn updated.
